muldiv_seq: RTL and testbench

//  Parametrised sequential RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_seq.sv | 133 +++++++++++++
 tb/tb_muldiv_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential RV32M-style multiply/divide unit with valid/ready handshake
module muldiv_seq #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  localparam int P  = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int CW = $clog2(XLEN);
  state_t            r_state;
  logic              r_valid;
  logic [XLEN-1:0]   r_res;
  logic [XLEN-1:0]   r_pipe [P];
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvs;
  logic [CW-1:0]     r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_rem_op;
  logic              w_a_sx;
  logic              w_b_sx;
  logic [2*XLEN+1:0] w_prod;
  logic [1:0]        w_unused;
  logic [XLEN-1:0]   w_mul;
  logic              w_sdiv;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_min;
  logic              w_b0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_sh;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  // MULHSU extends a as signed and b as unsigned; MULHU extends both as unsigned
  assign w_a_sx     = (op_i[1:0] != 2'b11) & a_i[XLEN-1];
  assign w_b_sx     = !op_i[1] & b_i[XLEN-1];
  assign w_prod     = $signed({w_a_sx, a_i}) * $signed({w_b_sx, b_i});
  assign w_unused   = w_prod[2*XLEN+1:2*XLEN];
  assign w_mul      = (op_i[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_sdiv     = !op_i[0];
  assign w_a_neg    = w_sdiv & a_i[XLEN-1];
  assign w_b_neg    = w_sdiv & b_i[XLEN-1];
  assign w_min      = {1'b1, {(XLEN-1){1'b0}}};
  assign w_b0       = (b_i == '0);
  assign w_ovf      = w_sdiv && (a_i == w_min) && (b_i == '1);
  assign w_fast     = w_b0 | w_ovf;
  assign w_fast_res = op_i[1] ? (w_b0 ? a_i : '0) : (w_b0 ? '1 : w_min);
  // one restoring shift-subtract step on the magnitudes
  assign w_sh       = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_sh - {1'b0, r_dvs};
  assign w_ge       = !w_diff[XLEN];
  assign ready_o    = (r_state == S_IDLE);
  assign busy_o     = (r_state != S_IDLE);
  assign valid_o    = r_valid;
  assign result_o   = r_res;
  // control FSM plus multiplier pipeline and divider datapath; result zeroed whenever not valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_res    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem_op <= 1'b0;
      for (int k = 0; k < P; k++) r_pipe[k] <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (valid_i) begin
          r_pipe[0] <= w_mul;
          r_quo     <= w_a_neg ? -a_i : a_i;
          r_dvs     <= w_b_neg ? -b_i : b_i;
          r_rem     <= '0;
          r_cnt     <= '0;
          r_neg_q   <= w_a_neg ^ w_b_neg;
          r_neg_r   <= w_a_neg;
          r_rem_op  <= op_i[1];
          r_state   <= !op_i[2] ? ((MUL_LAT == 1) ? S_DONE : S_MUL) : (w_fast ? S_DONE : S_DIV);
          r_valid   <= !op_i[2] ? (MUL_LAT == 1) : w_fast;
          r_res     <= !op_i[2] ? ((MUL_LAT == 1) ? w_mul : '0) : (w_fast ? w_fast_res : '0);
        end
        S_MUL: begin
          for (int k = 1; k < P; k++) r_pipe[k] <= r_pipe[k-1];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(MUL_LAT - 2)) begin
            r_res   <= r_pipe[P-1];
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem   <= w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
          r_quo   <= {r_quo[XLEN-2:0], w_ge};
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == CW'(XLEN - 1)) ? S_FIX : S_DIV;
        end
        S_FIX: begin
          r_res   <= r_rem_op ? (r_neg_r ? -r_rem : r_rem) : (r_neg_q ? -r_quo : r_quo);
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: if (ready_i) begin
          r_valid <= 1'b0;
          r_res   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: random and directed checks of muldiv_seq against a behavioural model
module tb_muldiv_seq;
  logic        clk_i = 1'b0;
  logic        rst_ni, valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i, result_o;
  int checks = 0, failures = 0;
  int rdy_pct = 100;
  bit chk_en = 1'b0;
  int e = 0, m_due = 0;
  logic m_pend = 1'b0;
  logic [31:0] m_res = '0;
  logic m_vld;

  muldiv_seq #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .busy_o(busy_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    bit ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a); ub = longint'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF; else if (ovf) r = a; else begin p = sa / sb; r = p[31:0]; end
      3'd5: if (b == 0) r = 32'hFFFF_FFFF; else begin p = ua / ub; r = p[31:0]; end
      3'd6: if (b == 0) r = a; else if (ovf) r = 0; else begin p = sa % sb; r = p[31:0]; end
      default: if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: one pending request, its due edge and its result
  assign m_vld = m_pend && (e >= m_due);
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) m_pend <= 1'b0;
    else begin
      e <= e + 1;
      if (flush_i) m_pend <= 1'b0;
      else if (!m_pend && valid_i) begin
        m_pend <= 1'b1;
        m_due  <= e + ref_lat(op_i, a_i, b_i);
        m_res  <= ref_res(op_i, a_i, b_i);
      end else if (m_vld && ready_i) m_pend <= 1'b0;
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("valid_o", valid_o, m_vld);
      chk("result_o", result_o, m_vld ? m_res : 32'h0);
      chk("ready_o", ready_o, !m_pend);
      chk("busy_o", busy_o, m_pend);
    end
  end

  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2 ready_i = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(posedge clk_i);
    #2 op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(negedge clk_i);
    while (!ready_o && n < 300) begin n++; @(negedge clk_i); end
    if (!ready_o) begin
      checks++; failures++;
      $display("FAIL accept_timeout: ready_o stayed %b, required 1", ready_o);
    end
    @(posedge clk_i);
    #2 valid_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    @(negedge clk_i);
    while (!valid_o && n < 100) begin n++; @(negedge clk_i); end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] res, input string nm);
    int n;
    chk({nm, "_model"}, ref_res(op, a, b), res);
    chk({nm, "_model_lat"}, ref_lat(op, a, b), lat);
    issue(op, a, b);
    wait_valid(n);
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_res"}, result_o, res);
  endtask

  initial begin
    int n, nv;
    rst_ni = 1'b1; valid_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_ready", ready_o, 1); chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0); chk("rst_result", result_o, 0);
    @(negedge clk_i); #1 rst_ni = 1'b1; chk_en = 1'b1;

    run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0001, "mul_m1");
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0000, "mulh_m1");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, "mulhu_max");
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF, "mulhsu");
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, "mulh_min");
    run(3'd4, -32'd7, 32'd2, 34, 32'hFFFF_FFFD, "div_neg");
    run(3'd6, -32'd7, 32'd2, 34, 32'hFFFF_FFFF, "rem_neg");
    run(3'd5, 32'd100, 32'd7, 34, 32'd14, "divu");
    run(3'd7, 32'd100, 32'd7, 34, 32'd2, "remu");
    run(3'd5, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "divu_by0");
    run(3'd7, 32'd5, 32'd0, 1, 32'd5, "remu_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, "rem_ovf");

    // backpressure: result held, second request waits for the handshake
    rdy_pct = 0;
    @(posedge clk_i);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, "bp");
    op_i = 3'd5; a_i = 32'd100; b_i = 32'd7; valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("bp_hold_res", result_o, 32'hFFFF_FFFE); chk("bp_hold_valid", valid_o, 1);
      chk("bp_hold_ready", ready_o, 0);
    end
    rdy_pct = 100;
    @(posedge clk_i); @(negedge clk_i);
    chk("bp_still_done", valid_o, 1);
    @(negedge clk_i);
    chk("bp_idle_ready", ready_o, 1); chk("bp_idle_valid", valid_o, 0);
    @(posedge clk_i); #2 valid_i = 1'b0;
    @(negedge clk_i);
    chk("bp_accepted", busy_o, 1);
    wait_valid(n);
    chk("bp_next_res", result_o, 32'd14);

    // flush in the middle of a divide
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk_i);
    #2 flush_i = 1'b1;
    @(posedge clk_i); #2 flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_ready", ready_o, 1); chk("flush_busy", busy_o, 0); chk("flush_valid", valid_o, 0);
    nv = 0;
    repeat (40) begin @(negedge clk_i); if (valid_o) nv++; end
    chk("flush_no_valid", nv, 0);

    // flush and request in the same cycle: request dropped
    @(posedge clk_i); #2 valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd4;
    @(posedge clk_i); #2 valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("flushreq_ready", ready_o, 1); chk("flushreq_busy", busy_o, 0);

    // asynchronous reset in the middle of a divide
    issue(3'd5, 32'd12345, 32'd17);
    repeat (4) @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("mrst_ready", ready_o, 1); chk("mrst_valid", valid_o, 0);
    chk("mrst_busy", busy_o, 0); chk("mrst_result", result_o, 0);
    @(negedge clk_i); #1 chk("mrst_hold_valid", valid_o, 0);
    @(negedge clk_i); #1 rst_ni = 1'b1;

    // random traffic with random backpressure and occasional flushes
    rdy_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      issue(3'($urandom), pick(), pick());
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 40)) @(posedge clk_i);
        #2 flush_i = 1'b1;
        @(posedge clk_i); #2 flush_i = 1'b0;
      end
    end
    rdy_pct = 100;
    repeat (60) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
